// File: rtl/aer_pkg.sv
// rtl/aer_pkg.sv - shared symbol codes, event indices and state types for the AER encoder
package aer_pkg;

  // Symbols as {Bit1, Bit0}
  localparam logic [1:0] SYM_FS     = 2'b11;
  localparam logic [1:0] SYM_ONE    = 2'b10;
  localparam logic [1:0] SYM_ZERO   = 2'b01;
  localparam logic [1:0] SYM_SPACER = 2'b00;

  // Event line indices, also the round-robin order
  localparam int         NUM_EV     = 4;
  localparam logic [1:0] EV_CH1UP   = 2'd0;
  localparam logic [1:0] EV_CH1DOWN = 2'd1;
  localparam logic [1:0] EV_CH2UP   = 2'd2;
  localparam logic [1:0] EV_CH2DOWN = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_FS,
    ST_S,
    ST_D,
    ST_FE
  } top_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_DRIVE,
    TX_RELEASE
  } tx_state_t;

  // Channel symbol: Ch2 events sit at indices 2 and 3
  function automatic logic [1:0] sym_chan(input logic [1:0] ev);
    return ev[1] ? SYM_ONE : SYM_ZERO;
  endfunction

  // Direction symbol: Up events sit at even indices
  function automatic logic [1:0] sym_dir(input logic [1:0] ev);
    return ev[0] ? SYM_ZERO : SYM_ONE;
  endfunction

endpackage

// File: rtl/aer_symbol_tx.sv
// rtl/aer_symbol_tx.sv - one-symbol return-to-zero handshake on Bit0/Bit1 with ack timeout
module aer_symbol_tx
  import aer_pkg::*;
#(
  parameter int ACK_SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT     = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sym_valid,
  input  logic [1:0] sym_data,
  output logic       sym_done,
  output logic       sym_timeout,
  input  logic       ack,
  output logic       Bit0,
  output logic       Bit1
);

  // Counter only needs to reach ACK_TIMEOUT-1
  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LIMIT = (ACK_TIMEOUT > 0) ? CNT_W'(ACK_TIMEOUT - 1) : '0;

  logic [ACK_SYNC_STAGES-1:0] ack_sync;
  logic                       ack_s;
  tx_state_t                  state_q, state_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [1:0]                 bits_q, bits_d;
  logic                       to_hit;

  assign ack_s  = ack_sync[ACK_SYNC_STAGES-1];
  assign to_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LIMIT);
  assign Bit0   = bits_q[0];
  assign Bit1   = bits_q[1];

  // Ack synchroniser shift chain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ack_sync <= '0;
    else        ack_sync <= {ack_sync[ACK_SYNC_STAGES-2:0], ack};
  end

  // State register plus wait counter and registered rails
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bits_q  <= SYM_SPACER;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
    end
  end

  // Next state: drive until ack high, release until ack low, abort on timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:    if (sym_valid) state_d = TX_DRIVE;
      TX_DRIVE:   if (ack_s) state_d = TX_RELEASE;
                  else if (to_hit) state_d = TX_IDLE;
      TX_RELEASE: if (!ack_s || to_hit) state_d = TX_IDLE;
      default:    state_d = TX_IDLE;
    endcase
  end

  // Outputs: handshake strobes, next rail value, counter restart on every phase change
  always_comb begin
    sym_done    = (state_q == TX_RELEASE) && !ack_s;
    sym_timeout = ((state_q == TX_DRIVE) && !ack_s && to_hit) ||
                  ((state_q == TX_RELEASE) && ack_s && to_hit);
    bits_d = bits_q;
    if (state_q == TX_IDLE && sym_valid) bits_d = sym_data;
    else if (state_q == TX_DRIVE && (ack_s || to_hit)) bits_d = SYM_SPACER;
    if (state_d != state_q)      cnt_d = '0;
    else if (state_q != TX_IDLE) cnt_d = cnt_q + CNT_W'(1);
    else                         cnt_d = '0;
  end

endmodule

// File: rtl/aer_input_encoder.sv
// rtl/aer_input_encoder.sv - AER link transmitter: event capture, round-robin arbitration, framing
module aer_input_encoder
  import aer_pkg::*;
#(
  parameter int ACK_SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT     = 1023,
  parameter int DROP_CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Ch1Up,
  input  logic                  Ch1Down,
  input  logic                  Ch2Up,
  input  logic                  Ch2Down,
  input  logic                  ack,
  output logic                  Bit0,
  output logic                  Bit1,
  output logic                  busy,
  output logic                  overflow,
  output logic                  timeout_err,
  output logic [DROP_CNT_W-1:0] drop_count
);

  top_state_t            state_q, state_d;
  logic [NUM_EV-1:0]     ev_in, ev_q, ev_edge, pending_q, grant_clr, drops;
  logic [1:0]            ptr_q, sel_q, grant_idx, probe;
  logic                  grant_valid;
  logic                  sym_valid, sym_done, sym_timeout;
  logic [1:0]            sym_data;
  logic                  overflow_q, timeout_q;
  logic [DROP_CNT_W-1:0] drop_q, drop_next;
  logic [DROP_CNT_W:0]   drop_sum;
  logic [2:0]            drop_add;

  assign ev_in       = {Ch2Down, Ch2Up, Ch1Down, Ch1Up};
  assign ev_edge     = ev_in & ~ev_q;
  assign drops       = ev_edge & pending_q & ~grant_clr;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;
  assign drop_count  = drop_q;
  assign busy        = (state_q != ST_IDLE) || (|pending_q);

  // Round-robin: first pending line at or after the pointer; lowest offset wins
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    probe       = ptr_q;
    for (int i = NUM_EV - 1; i >= 0; i--) begin
      probe = ptr_q + 2'(i);
      if (pending_q[probe]) begin
        grant_valid = 1'b1;
        grant_idx   = probe;
      end
    end
  end

  // Saturating drop counter increment (several lines can drop in one cycle)
  always_comb begin
    drop_add  = 3'(drops[0]) + 3'(drops[1]) + 3'(drops[2]) + 3'(drops[3]);
    drop_sum  = {1'b0, drop_q} + (DROP_CNT_W + 1)'(drop_add);
    drop_next = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  // Top FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: one handshake per frame symbol, timeout drops the frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|pending_q) state_d = ST_SEL;
      ST_SEL:  state_d = grant_valid ? ST_FS : ST_IDLE;
      ST_FS:   if (sym_timeout) state_d = ST_IDLE; else if (sym_done) state_d = ST_S;
      ST_S:    if (sym_timeout) state_d = ST_IDLE; else if (sym_done) state_d = ST_D;
      ST_D:    if (sym_timeout) state_d = ST_IDLE; else if (sym_done) state_d = ST_FE;
      ST_FE:   if (sym_timeout) state_d = ST_IDLE;
               else if (sym_done) state_d = (|pending_q) ? ST_SEL : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: symbol request to the handshake engine and flag clear on grant
  always_comb begin
    sym_valid = 1'b0;
    sym_data  = SYM_SPACER;
    grant_clr = '0;
    case (state_q)
      ST_SEL:  if (grant_valid) grant_clr = NUM_EV'(1) << grant_idx;
      ST_FS:   begin sym_valid = 1'b1; sym_data = SYM_FS;         end
      ST_S:    begin sym_valid = 1'b1; sym_data = sym_chan(sel_q); end
      ST_D:    begin sym_valid = 1'b1; sym_data = sym_dir(sel_q);  end
      ST_FE:   begin sym_valid = 1'b1; sym_data = SYM_FS;         end
      default: ;
    endcase
  end

  // Capture, pending flags, pointer, sticky errors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ev_q       <= '0;
      pending_q  <= '0;
      ptr_q      <= EV_CH1UP;
      sel_q      <= EV_CH1UP;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
      drop_q     <= '0;
    end else begin
      ev_q      <= ev_in;
      pending_q <= (pending_q & ~grant_clr) | ev_edge;
      if (|grant_clr) begin
        sel_q <= grant_idx;
        ptr_q <= grant_idx + 2'd1;
      end
      if (|drops) overflow_q <= 1'b1;
      drop_q <= drop_next;
      if (sym_timeout) timeout_q <= 1'b1;
    end
  end

  aer_symbol_tx #(
    .ACK_SYNC_STAGES (ACK_SYNC_STAGES),
    .ACK_TIMEOUT     (ACK_TIMEOUT)
  ) u_tx (
    .clk         (clk),
    .reset       (reset),
    .sym_valid   (sym_valid),
    .sym_data    (sym_data),
    .sym_done    (sym_done),
    .sym_timeout (sym_timeout),
    .ack         (ack),
    .Bit0        (Bit0),
    .Bit1        (Bit1)
  );

endmodule

// File: tb/tb_aer_input_encoder.sv
// tb/tb_aer_input_encoder.sv - directed self-checking bench for aer_input_encoder
module tb_aer_input_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] ev = 4'h0;
  logic       ack = 1'b0;
  logic       Bit0, Bit1, busy, overflow, timeout_err;
  logic [7:0] drop_count;
  logic [1:0] w;

  int   n_pass = 0;
  int   n_total = 0;
  logic resp_en = 1'b1;
  logic rec_en = 1'b0;
  logic [1:0] prev = 2'b00;
  logic [1:0] q[$];
  logic [1:0] syms[$];
  logic       alt_ok;

  assign w = {Bit1, Bit0};

  always #5 clk = ~clk;

  aer_input_encoder #(
    .ACK_SYNC_STAGES (2),
    .ACK_TIMEOUT     (15),
    .DROP_CNT_W      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Ch1Up       (ev[0]),
    .Ch1Down     (ev[1]),
    .Ch2Up       (ev[2]),
    .Ch2Down     (ev[3]),
    .ack         (ack),
    .Bit0        (Bit0),
    .Bit1        (Bit1),
    .busy        (busy),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .drop_count  (drop_count)
  );

  // Receiver model: 3-cycle delay on each ack transition
  initial begin
    forever begin
      @(negedge clk);
      if (!resp_en) ack = 1'b0;
      else if (!ack && w != 2'b00) begin
        repeat (3) @(negedge clk);
        if (resp_en) ack = 1'b1;
      end else if (ack && w == 2'b00) begin
        repeat (3) @(negedge clk);
        ack = 1'b0;
      end
    end
  end

  // Wire monitor: log every change of {Bit1,Bit0}
  initial begin
    forever begin
      @(negedge clk);
      if (rec_en && w != prev) q.push_back(w);
      prev = w;
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    ev = m;
    tick;
    ev = 4'h0;
    tick;
  endtask

  task automatic start_rec;
    q.delete();
    rec_en = 1'b1;
  endtask

  function automatic int count_syms();
    int c = 0;
    foreach (q[i]) if (q[i] != 2'b00) c++;
    return c;
  endfunction

  task automatic decode;
    syms.delete();
    alt_ok = 1'b1;
    foreach (q[i]) begin
      if ((i % 2) == 0) alt_ok = alt_ok && (q[i] != 2'b00);
      else              alt_ok = alt_ok && (q[i] == 2'b00);
      if (q[i] != 2'b00) syms.push_back(q[i]);
    end
  endtask

  function automatic logic [7:0] frame_at(input int k);
    if (4 * k + 3 >= syms.size()) return 8'h00;
    return {syms[4*k], syms[4*k+1], syms[4*k+2], syms[4*k+3]};
  endfunction

  task automatic wait_syms(input int n, input string name);
    int t = 0;
    while (count_syms() < n && t < 3000) begin tick; t++; end
    n_total++;
    if (count_syms() < n) $display("FAIL %s_wait symbols=%0d need=%0d", name, count_syms(), n);
    else n_pass++;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (!(busy == 1'b0 && ack == 1'b0 && w == 2'b00) && t < 3000) begin tick; t++; end
    n_total++;
    if (busy !== 1'b0) $display("FAIL %s_idle_wait busy=%0b need=0", name, busy);
    else n_pass++;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    ev = 4'h0;
    repeat (3) tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_reset;
    do_reset;
    n_total++; if (Bit0 !== 1'b0) $display("FAIL reset_bit0 got=%0b exp=0", Bit0); else n_pass++;
    n_total++; if (Bit1 !== 1'b0) $display("FAIL reset_bit1 got=%0b exp=0", Bit1); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got=%0b exp=0", overflow); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got=%0b exp=0", timeout_err); else n_pass++;
    n_total++; if (drop_count !== 8'd0) $display("FAIL reset_drop_count got=%0d exp=0", drop_count); else n_pass++;
  endtask

  task automatic test_single;
    int k;
    logic [15:0] got;
    start_rec;
    ev = 4'b0001;
    k = 0;
    while (w != 2'b11 && k < 20) begin
      tick; k++;
      if (k == 1) ev = 4'h0;
    end
    n_total++; if (k - 1 != 3) $display("FAIL single_latency got=%0d exp=3", k - 1); else n_pass++;
    wait_syms(4, "single");
    while (q.size() < 8 && k < 500) begin tick; k++; end
    n_total++; if (busy !== 1'b1) $display("FAIL single_busy_at_fe_spacer got=%0b exp=1", busy); else n_pass++;
    wait_idle("single");
    n_total++; if (ack !== 1'b0) $display("FAIL single_ack_at_busy_fall got=%0b exp=0", ack); else n_pass++;
    n_total++; if (q.size() != 8) $display("FAIL single_transitions got=%0d exp=8", q.size()); else n_pass++;
    got = 16'h0;
    if (q.size() == 8) foreach (q[i]) got = {got[13:0], q[i]};
    n_total++; if (got !== 16'hC48C) $display("FAIL single_wire_seq got=%h exp=c48c", got); else n_pass++;
    n_total++; if (drop_count !== 8'd0) $display("FAIL single_drop_count got=%0d exp=0", drop_count); else n_pass++;
    rec_en = 1'b0;
  endtask

  task automatic test_pointer;
    do_reset;
    start_rec;
    pulse(4'b1000);
    wait_idle("ptr_a");
    pulse(4'b1001);
    wait_idle("ptr_b");
    decode;
    n_total++; if (syms.size() != 12) $display("FAIL ptr_symbols got=%0d exp=12", syms.size()); else n_pass++;
    n_total++; if (frame_at(0) !== 8'hE7) $display("FAIL ptr_ch2down_frame got=%h exp=e7", frame_at(0)); else n_pass++;
    n_total++; if (frame_at(1) !== 8'hDB) $display("FAIL ptr_wrap_first got=%h exp=db", frame_at(1)); else n_pass++;
    n_total++; if (frame_at(2) !== 8'hE7) $display("FAIL ptr_wrap_second got=%h exp=e7", frame_at(2)); else n_pass++;
    rec_en = 1'b0;
  endtask

  task automatic test_all_four;
    do_reset;
    start_rec;
    pulse(4'b1111);
    wait_idle("all4");
    decode;
    n_total++; if (syms.size() != 16) $display("FAIL all4_symbols got=%0d exp=16", syms.size()); else n_pass++;
    n_total++; if (alt_ok !== 1'b1) $display("FAIL all4_spacer_alternation got=%0b exp=1", alt_ok); else n_pass++;
    n_total++; if (frame_at(0) !== 8'hDB) $display("FAIL all4_frame0 got=%h exp=db", frame_at(0)); else n_pass++;
    n_total++; if (frame_at(1) !== 8'hD7) $display("FAIL all4_frame1 got=%h exp=d7", frame_at(1)); else n_pass++;
    n_total++; if (frame_at(2) !== 8'hEB) $display("FAIL all4_frame2 got=%h exp=eb", frame_at(2)); else n_pass++;
    n_total++; if (frame_at(3) !== 8'hE7) $display("FAIL all4_frame3 got=%h exp=e7", frame_at(3)); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL all4_overflow got=%0b exp=0", overflow); else n_pass++;
    rec_en = 1'b0;
  endtask

  task automatic test_overflow;
    do_reset;
    start_rec;
    pulse(4'b0100);
    wait_syms(1, "ovf_first");
    pulse(4'b0001);
    pulse(4'b0001);
    wait_syms(5, "ovf_second");
    pulse(4'b0001);
    wait_idle("ovf");
    decode;
    n_total++; if (syms.size() != 12) $display("FAIL ovf_symbols got=%0d exp=12", syms.size()); else n_pass++;
    n_total++; if (frame_at(0) !== 8'hEB) $display("FAIL ovf_frame0 got=%h exp=eb", frame_at(0)); else n_pass++;
    n_total++; if (frame_at(1) !== 8'hDB) $display("FAIL ovf_frame1 got=%h exp=db", frame_at(1)); else n_pass++;
    n_total++; if (frame_at(2) !== 8'hDB) $display("FAIL ovf_frame2 got=%h exp=db", frame_at(2)); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_overflow got=%0b exp=1", overflow); else n_pass++;
    n_total++; if (drop_count !== 8'd1) $display("FAIL ovf_drop_count got=%0d exp=1", drop_count); else n_pass++;
    rec_en = 1'b0;
  endtask

  task automatic test_timeout;
    int t;
    int n;
    resp_en = 1'b0;
    tick;
    pulse(4'b0001);
    t = 0;
    while (w != 2'b11 && t < 100) begin tick; t++; end
    n = 0;
    while (w == 2'b11 && n < 100) begin n++; tick; end
    n_total++; if (n != 15) $display("FAIL to_fs_cycles got=%0d exp=15", n); else n_pass++;
    n_total++; if (w !== 2'b00) $display("FAIL to_wires got=%b exp=00", w); else n_pass++;
    n_total++; if (timeout_err !== 1'b1) $display("FAIL to_timeout_err got=%0b exp=1", timeout_err); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL to_busy got=%0b exp=0", busy); else n_pass++;
    repeat (30) tick;
    n_total++; if (w !== 2'b00) $display("FAIL to_wires_stay_idle got=%b exp=00", w); else n_pass++;
    resp_en = 1'b1;
  endtask

  task automatic test_reset_mid_frame;
    start_rec;
    pulse(4'b0001);
    wait_syms(3, "rst_mid");
    n_total++; if (w !== 2'b10) $display("FAIL rst_mid_d_symbol got=%b exp=10", w); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (w !== 2'b00) $display("FAIL rst_mid_wires got=%b exp=00", w); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got=%0b exp=0", busy); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_mid_overflow got=%0b exp=0", overflow); else n_pass++;
    n_total++; if (timeout_err !== 1'b0) $display("FAIL rst_mid_timeout_err got=%0b exp=0", timeout_err); else n_pass++;
    n_total++; if (drop_count !== 8'd0) $display("FAIL rst_mid_drop_count got=%0d exp=0", drop_count); else n_pass++;
    rec_en = 1'b0;
    repeat (3) tick;
    reset = 1'b1;
    repeat (20) tick;
    n_total++; if (w !== 2'b00) $display("FAIL rst_after_wires got=%b exp=00", w); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL rst_after_busy got=%0b exp=0", busy); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_pointer;
    test_all_four;
    test_overflow;
    test_timeout;
    test_reset_mid_frame;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/aer_input_encoder.md
Name: aer_input_encoder

Overview:
- Transmit end of the two-wire AER link; its frames are consumed by the receiver/decoder that drives Ch1Up/Ch1Down/Ch2Up/Ch2Down.
- Captures channel spike events, queues one pending flag per event line and arbitrates round-robin between them.
- Serialises each event as a 4-symbol frame on Bit0/Bit1 using a return-to-zero 4-phase handshake against ack.
- Fully synchronous to clk; ack is asynchronous and is synchronised internally.

Parameters:
ACK_SYNC_STAGES, 2, flip-flop stages on the ack input (minimum 2)
ACK_TIMEOUT, 1023, clk cycles allowed per handshake wait before abort; 0 disables the timeout
DROP_CNT_W, 8, width of the saturating dropped-event counter

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
Ch1Up  input  1  channel 1 up event, synchronous to clk, rising edge = event
Ch1Down  input  1  channel 1 down event
Ch2Up  input  1  channel 2 up event
Ch2Down  input  1  channel 2 down event
ack  input  1  receiver acknowledge, asynchronous
Bit0  output  1  zero rail
Bit1  output  1  one rail
busy  output  1  frame in flight or any event pending
overflow  output  1  sticky; an event arrived while its flag was already pending
timeout_err  output  1  sticky; a handshake wait exceeded ACK_TIMEOUT
drop_count  output  DROP_CNT_W  saturating count of dropped events

Behaviour:
- Reset (reset=0, asynchronous):
  - Bit0, Bit1, busy, overflow, timeout_err and drop_count all go to 0.
  - Pending flags, edge registers and the ack synchroniser clear.
  - The round-robin pointer is set to Ch1Up.
- Symbols, given as (Bit1,Bit0): Fs/Fe = 11, One = 10, Zero = 01, spacer = 00. Bit0/Bit1 are registered, so there are no glitches.
- Frame: Fs, S, D, Fe.
  - S = channel: Zero for Ch1, One for Ch2.
  - D = direction: One for Up, Zero for Down.
- Per-symbol handshake:
  - Drive the symbol.
  - Wait for synced ack=1, then drive the spacer.
  - Wait for synced ack=0, then advance to the next symbol.
  - The next symbol is driven on the cycle after ack=0 is observed.
- Capture:
  - A rising edge on an event input sets its pending flag in the next cycle.
  - Simultaneous edges on several inputs all set their flags.
  - An edge on a line whose flag is already set: set overflow and increment drop_count, saturating at all-ones.
  - A flag is cleared when its event is selected. An edge on the line currently being transmitted therefore queues a new event.
- Top FSM states: IDLE, SEL, FS, S, D, FE.
  - IDLE -> SEL when any flag is set.
  - SEL: grant the first set flag at or after the pointer, in the order Ch1Up, Ch1Down, Ch2Up, Ch2Down. Clear that flag, latch S/D, and move the pointer to the next line. Then go to FS.
  - FS -> S -> D -> FE, each state advancing on completion of its handshake.
  - FE -> SEL if any flag is set, otherwise IDLE.
- Latency: an edge sampled at cycle N produces Fs on the wires at cycle N+3 when idle (capture, IDLE->SEL, SEL->FS).
- Timeout:
  - The counter restarts at each wait phase.
  - On reaching ACK_TIMEOUT: drive the spacer, set timeout_err, discard the current frame, return to IDLE.
  - Pending flags are kept. timeout_err is cleared only by reset.
- Ack misbehaviour: ack already high when a symbol is driven is treated as an acknowledge. The receiver is responsible for 4-phase correctness.
- busy = (state != IDLE) or any flag set.

Decomposition:
- Package aer_pkg:
  - symbol constants SYM_FS, SYM_ONE, SYM_ZERO, SYM_SPACER (2-bit, {Bit1,Bit0});
  - event index constants EV_CH1UP..EV_CH2DOWN;
  - top FSM state enum.
- Sub-module aer_symbol_tx:
  - contains the ack synchroniser, the DRIVE/RELEASE handshake FSM and the timeout counter;
  - interface: sym_valid/sym_data in, sym_done/sym_timeout out, Bit0/Bit1/ack at the pins.

Test Plan:
- Single Ch1Up with a 3-cycle-delay ack responder -> wires 11,00,01,00,10,00,11,00; drop_count=0; busy falls after the final ack=0.
- Ch2Down alone -> frame 11,10,01,11; pointer now at Ch1Up.
- All four inputs rise in the same cycle -> four frames in order Ch1Up, Ch1Down, Ch2Up, Ch2Down; no overflow.
- Ch1Up edge, then a second Ch1Up edge before SEL, then a third edge after SEL -> overflow=1, drop_count=1, exactly two Ch1Up frames sent.
- ACK_TIMEOUT=15 and ack held at 0 -> after Fs has been driven for 15 cycles the wires go to 00, timeout_err=1, FSM returns to IDLE.
- Reset asserted mid-frame during D with Bit1=1 -> Bit0/Bit1 go to 0 immediately and all outputs read 0. After release with no events the outputs stay idle.
